// File: rtl/bus_arbiter_pkg.sv
// Shared widths, FSM encoding and bus command payload for the IF/MEM bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned RegBus        = 32;
  localparam int unsigned InstAddrBus   = 32;
  localparam int unsigned ByteSelBus    = 4;
  localparam int unsigned ArbTimeoutDef = 255;
  localparam int unsigned ArbCntW       = 8;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusyMem = 2'd1,
    ArbBusyIf  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [RegBus-1:0]     addr;
    logic                  we;
    logic [ByteSelBus-1:0] sel;
    logic [RegBus-1:0]     wdata;
  } bus_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_cmd_t fetch_cmd(input logic [InstAddrBus-1:0] addr);
    bus_cmd_t c;
    c.addr  = RegBus'(addr);
    c.we    = 1'b0;
    c.sel   = {ByteSelBus{1'b1}};
    c.wdata = {RegBus{1'b0}};
    return c;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (fetch, data) to one-slave bus arbiter with MEM priority from idle,
// alternation on completion, per-transaction timeout abort and pipeline stall request.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = ArbTimeoutDef
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    if_req_i,
  input  logic [InstAddrBus-1:0]  if_addr_i,
  output logic [RegBus-1:0]       if_rdata_o,
  output logic                    if_ack_o,

  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [ByteSelBus-1:0]   mem_sel_i,
  input  logic [RegBus-1:0]       mem_addr_i,
  input  logic [RegBus-1:0]       mem_wdata_i,
  output logic [RegBus-1:0]       mem_rdata_o,
  output logic                    mem_ack_o,

  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ByteSelBus-1:0]   bus_sel_o,
  output logic [RegBus-1:0]       bus_addr_o,
  output logic [RegBus-1:0]       bus_wdata_o,
  input  logic [RegBus-1:0]       bus_rdata_i,
  input  logic                    bus_ack_i,

  output logic                    stallreq_o,
  output logic                    bus_err_o
);

  arb_state_e          r_state, w_next_state;
  bus_cmd_t            r_cmd, w_cmd;
  logic [ArbCntW-1:0]  r_cnt, w_cnt;
  logic                r_bus_req, w_bus_req;
  logic                r_if_ack, w_if_ack;
  logic                r_mem_ack, w_mem_ack;
  logic                r_err, w_err;
  logic [RegBus-1:0]   r_if_rdata, w_if_rdata;
  logic [RegBus-1:0]   r_mem_rdata, w_mem_rdata;

  logic                w_if_req, w_mem_req;
  logic                w_busy, w_timeout, w_done;
  logic [RegBus-1:0]   w_resp_data;

  // A requester's line is still high during its own ack cycle; that is not a new request.
  assign w_if_req    = if_req_i  & ~r_if_ack;
  assign w_mem_req   = mem_req_i & ~r_mem_ack;

  assign w_busy      = (r_state != ArbIdle);
  assign w_timeout   = w_busy & ~bus_ack_i & (r_cnt == ArbCntW'(TIMEOUT_CYC - 1));
  assign w_done      = w_busy & (bus_ack_i | w_timeout);
  assign w_resp_data = w_timeout ? {RegBus{1'b0}} : bus_rdata_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ArbIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: MEM wins from idle, completions hand the bus to the other port
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ArbIdle: begin
        if (w_mem_req) begin
          w_next_state = ArbBusyMem;
        end else if (w_if_req) begin
          w_next_state = ArbBusyIf;
        end
      end
      ArbBusyMem: begin
        if (w_done) begin
          w_next_state = w_if_req ? ArbBusyIf : ArbIdle;
        end
      end
      ArbBusyIf: begin
        if (w_done) begin
          w_next_state = w_mem_req ? ArbBusyMem : ArbIdle;
        end
      end
      default: w_next_state = ArbIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_cmd       = r_cmd;
    w_cnt       = {ArbCntW{1'b0}};
    w_bus_req   = (w_next_state != ArbIdle);
    w_if_ack    = 1'b0;
    w_mem_ack   = 1'b0;
    w_err       = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_mem_rdata = r_mem_rdata;

    if (w_busy && !w_done) begin
      w_cnt = r_cnt + ArbCntW'(1);
    end

    if (w_done) begin
      w_err = w_timeout;
      if (r_state == ArbBusyMem) begin
        w_mem_ack   = 1'b1;
        w_mem_rdata = w_resp_data;
      end else begin
        w_if_ack    = 1'b1;
        w_if_rdata  = w_resp_data;
      end
    end

    // Latch the command only on a fresh grant, including a chained one.
    if ((w_next_state == ArbBusyMem) && (r_state != ArbBusyMem)) begin
      w_cmd = '{addr: mem_addr_i, we: mem_we_i, sel: mem_sel_i, wdata: mem_wdata_i};
    end else if ((w_next_state == ArbBusyIf) && (r_state != ArbBusyIf)) begin
      w_cmd = fetch_cmd(if_addr_i);
    end
  end

  // Registered outputs, counter and command latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd       <= '0;
      r_cnt       <= {ArbCntW{1'b0}};
      r_bus_req   <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= {RegBus{1'b0}};
      r_mem_rdata <= {RegBus{1'b0}};
    end else begin
      r_cmd       <= w_cmd;
      r_cnt       <= w_cnt;
      r_bus_req   <= w_bus_req;
      r_if_ack    <= w_if_ack;
      r_mem_ack   <= w_mem_ack;
      r_err       <= w_err;
      r_if_rdata  <= w_if_rdata;
      r_mem_rdata <= w_mem_rdata;
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_cmd.we;
  assign bus_sel_o   = r_cmd.sel;
  assign bus_addr_o  = r_cmd.addr;
  assign bus_wdata_o = r_cmd.wdata;
  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_rdata;
  assign bus_err_o   = r_err;

  assign stallreq_o  = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: slave model, ack scoreboard and per-scenario tasks.
module tb_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        bus_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
    bit          err;
    bit          chk;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic slave_on   = 1'b0;
  int   slave_wait = 0;
  logic stray_ack  = 1'b0;
  int   slave_cnt;

  bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] r;
    if (a == 32'h0000_0040) r = 32'h2401_0005;
    else                    r = {a[15:0], ~a[15:0]};
    return r;
  endfunction

  // Slave: acks after slave_wait wait states of an asserted strobe.
  always @(posedge clk or posedge rst) begin
    if (rst)                          slave_cnt <= 0;
    else if (bus_req_o && !bus_ack_i) slave_cnt <= slave_cnt + 1;
    else                              slave_cnt <= 0;
  end
  assign bus_ack_i   = stray_ack | (slave_on & bus_req_o & (slave_cnt == slave_wait));
  assign bus_rdata_i = model_rdata(bus_addr_o);

  function automatic logic [136:0] all_regs();
    return {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, if_ack_o, mem_ack_o,
            if_rdata_o, mem_rdata_o, bus_err_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack pulse must match the oldest expected completion.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (if_ack_o || mem_ack_o)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ack: if_ack=%0b mem_ack=%0b, none expected", if_ack_o, mem_ack_o);
        end else begin
          mon_e = sb.pop_front();
          if ((mem_ack_o !== mon_e.is_mem) || (if_ack_o === mem_ack_o) || (bus_err_o !== mon_e.err) ||
              (mon_e.chk && ((mon_e.is_mem ? mem_rdata_o : if_rdata_o) !== mon_e.rdata))) begin
            n_bad++;
            $display("FAIL sb_ack: got mem_ack=%0b if_ack=%0b err=%0b rdata=%h/%h, want mem=%0b err=%0b rdata=%h",
                     mem_ack_o, if_ack_o, bus_err_o, mem_rdata_o, if_rdata_o,
                     mon_e.is_mem, mon_e.err, mon_e.rdata);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0; mem_req_i = 0; mem_we_i = 0; mem_sel_i = '0;
    mem_addr_i = '0; mem_wdata_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (all_regs() !== '0 || stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h stall=%0b, want all 0", all_regs(), stallreq_o);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: bus_req=%0b stall=%0b, want 0/0", bus_req_o, stallreq_o);
    end
    tick();
  endtask

  task automatic test_single_fetch(input logic [31:0] addr);
    slave_on = 1'b1; slave_wait = 0;
    if_req_i = 1'b1; if_addr_i = addr;
    sb.push_back('{is_mem: 1'b0, rdata: model_rdata(addr), err: 1'b0, chk: 1'b1});
    @(negedge clk);
    n_cmp++;
    if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c0: stall=%0b bus_req=%0b, want 1/0", stallreq_o, bus_req_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== addr || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF ||
        stallreq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_c1: req=%0b addr=%h we=%0b sel=%h stall=%0b, want 1 %h 0 f 1",
               bus_req_o, bus_addr_o, bus_we_o, bus_sel_o, stallreq_o, addr);
    end
    @(negedge clk);
    n_cmp++;
    if (if_ack_o !== 1'b1 || mem_ack_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c2: if_ack=%0b mem_ack=%0b stall=%0b, want 1/0/0", if_ack_o, mem_ack_o, stallreq_o);
    end
    tick();
    if_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_req_o !== 1'b0 || if_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c3: bus_req=%0b if_ack=%0b, want 0/0", bus_req_o, if_ack_o);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    int mem_c = -1, if_c = -1, gaps = 0;
    logic we1, we3;
    logic [31:0] a1, d1, a3;
    slave_on = 1'b1; slave_wait = 1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0080;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
    mem_addr_i = 32'h0000_0100; mem_wdata_i = 32'hDEAD_BEEF;
    sb.push_back('{is_mem: 1'b1, rdata: '0, err: 1'b0, chk: 1'b0});
    sb.push_back('{is_mem: 1'b0, rdata: model_rdata(32'h80), err: 1'b0, chk: 1'b1});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4 && !bus_req_o) gaps++;
      if (c == 1) begin we1 = bus_we_o; a1 = bus_addr_o; d1 = bus_wdata_o; end
      if (c == 3) begin we3 = bus_we_o; a3 = bus_addr_o; end
      if (mem_ack_o) mem_c = c;
      if (if_ack_o)  if_c  = c;
      tick();
      if (mem_c >= 0) mem_req_i = 1'b0;
      if (if_c >= 0)  if_req_i  = 1'b0;
    end
    n_cmp++;
    if (we1 !== 1'b1 || a1 !== 32'h100 || d1 !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL sim_mem_first: we=%0b addr=%h wdata=%h, want 1 00000100 deadbeef", we1, a1, d1);
    end
    n_cmp++;
    if (we3 !== 1'b0 || a3 !== 32'h80) begin
      n_bad++;
      $display("FAIL sim_if_cmd: we=%0b addr=%h, want 0 00000080", we3, a3);
    end
    n_cmp++;
    if (mem_c != 3) begin
      n_bad++;
      $display("FAIL sim_mem_ack_cycle: got %0d, want 3", mem_c);
    end
    n_cmp++;
    if (if_c != 5) begin
      n_bad++;
      $display("FAIL sim_if_ack_cycle: got %0d, want 5", if_c);
    end
    n_cmp++;
    if (gaps != 0) begin
      n_bad++;
      $display("FAIL sim_no_bubble: idle cycles=%0d, want 0", gaps);
    end
  endtask

  task automatic test_alternation();
    int m_n = 0, i_n = 0, gaps = 0, cyc = 0, late = 0;
    slave_on = 1'b1; slave_wait = 1;
    mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0200; mem_wdata_i = '0;
    if_addr_i = 32'h0000_00C0;
    mem_req_i = 1'b1; if_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{is_mem: 1'b1, rdata: model_rdata(32'h200), err: 1'b0, chk: 1'b1});
      sb.push_back('{is_mem: 1'b0, rdata: model_rdata(32'hC0),  err: 1'b0, chk: 1'b1});
    end
    while ((m_n < 4 || i_n < 4) && cyc < 60) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 16 && !bus_req_o) gaps++;
      if (mem_ack_o) m_n++;
      if (if_ack_o)  i_n++;
      tick();
      if (m_n == 4) mem_req_i = 1'b0;
      if (i_n == 4) if_req_i  = 1'b0;
      cyc++;
    end
    n_cmp++;
    if (m_n != 4 || i_n != 4) begin
      n_bad++;
      $display("FAIL alt_count: mem=%0d if=%0d after %0d cycles, want 4/4", m_n, i_n, cyc);
    end
    n_cmp++;
    if (gaps != 0) begin
      n_bad++;
      $display("FAIL alt_no_bubble: idle cycles=%0d, want 0", gaps);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus_req_o) late++;
    end
    n_cmp++;
    if (late != 0) begin
      n_bad++;
      $display("FAIL alt_idle_after: bus_req cycles=%0d, want 0", late);
    end
    tick();
  endtask

  task automatic test_timeout();
    int ack_c = -1, err_n = 0, busy_after = 0;
    logic err_at_ack = 1'b0;
    slave_on = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0300;
    sb.push_back('{is_mem: 1'b1, rdata: 32'h0, err: 1'b1, chk: 1'b1});
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (bus_err_o) err_n++;
      if (mem_ack_o) begin ack_c = c; err_at_ack = bus_err_o; end
      if (c >= 6 && bus_req_o) busy_after++;
      tick();
      if (ack_c >= 0) mem_req_i = 1'b0;
    end
    n_cmp++;
    if (ack_c != int'(TO) + 1) begin
      n_bad++;
      $display("FAIL to_ack_cycle: got %0d, want %0d", ack_c, TO + 1);
    end
    n_cmp++;
    if (err_n != 1 || err_at_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL to_err_pulse: err cycles=%0d with_ack=%0b, want 1/1", err_n, err_at_ack);
    end
    n_cmp++;
    if (busy_after != 0) begin
      n_bad++;
      $display("FAIL to_idle: bus_req cycles after abort=%0d, want 0", busy_after);
    end
    slave_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    slave_on = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0044;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h44) begin
      n_bad++;
      $display("FAIL rstmid_busy: bus_req=%0b addr=%h, want 1 00000044", bus_req_o, bus_addr_o);
    end
    #2;
    rst = 1'b1;
    if_req_i = 1'b0;
    #1;
    n_cmp++;
    if (all_regs() !== '0 || stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got %h stall=%0b, want all 0", all_regs(), stallreq_o);
    end
    tick();
    rst = 1'b0;
    slave_on = 1'b1;
    stray_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_ack_o || mem_ack_o || bus_req_o || bus_err_o) bad++;
    end
    tick();
    stray_ack = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rstmid_stray_ack: active cycles=%0d, want 0", bad);
    end
  endtask

  task automatic test_stale_ack();
    int bad = 0;
    stray_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if_ack_o || mem_ack_o || bus_req_o || bus_err_o) bad++;
    end
    tick();
    stray_ack = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stale_ack: active cycles=%0d, want 0", bad);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch(32'h0000_0040);
    test_simultaneous();
    test_alternation();
    test_timeout();
    test_reset_mid();
    test_stale_ack();
    test_single_fetch(32'h0000_01F0);
    repeat (3) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expected acks never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter that shares a single-port memory bus between the instruction-fetch port and the data-access (MEM-stage) port of the five-stage pipeline. It sits between `openmips` and the unified SRAM/bus and replaces the dedicated ROM connection. Each granted transaction runs until the slave acknowledges or a timeout fires. While any requester is waiting, the block drives a stall request to the pipeline.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: maximum cycles a granted transaction may wait for `bus_ack_i` before it is aborted. Legal range is 1..255.

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req_i`  in  1  fetch request; held with address until `if_ack_o`
- `if_addr_i`  in  32  fetch address
- `if_rdata_o`  out  32  fetched word, valid while `if_ack_o` is high
- `if_ack_o`  out  1  one-cycle completion pulse
- `mem_req_i`  in  1  data request; held until `mem_ack_o`
- `mem_we_i`  in  1  1 = write
- `mem_sel_i`  in  4  byte enables
- `mem_addr_i`  in  32  data address
- `mem_wdata_i`  in  32  write data
- `mem_rdata_o`  out  32  read data, valid while `mem_ack_o` is high
- `mem_ack_o`  out  1  one-cycle completion pulse
- `bus_req_o`, `bus_we_o`  out  1  slave strobe / write enable
- `bus_sel_o`  out  4;  `bus_addr_o`, `bus_wdata_o`  out  32  slave command
- `bus_rdata_i`  in  32;  `bus_ack_i`  in  1  slave response
- `stallreq_o`  out  1  pipeline stall request
- `bus_err_o`  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: `IDLE`, `BUSY_MEM`, `BUSY_IF`.
- **Masking.** A requester whose `*_ack_o` is high in the current cycle has its `*_req_i` ignored for that cycle. Its request line is still high from the transaction just completed.
- **IDLE.** On an edge with unmasked `mem_req_i`, go to `BUSY_MEM`. Otherwise, on unmasked `if_req_i`, go to `BUSY_IF`. MEM has priority.
- **Grant edge.** At the grant edge, latch the command: addr/we/sel/wdata from the MEM port. For IF, latch `if_addr_i`, with `we=0` and `sel=4'b1111`.
- **BUSY_x.**
  - `bus_req_o` is 1 and the bus command outputs carry the latched registers.
  - The wait counter increments each cycle.
- **Completion (ack).** On an edge with `bus_ack_i=1`:
  - register `bus_rdata_i` into `x_rdata_o` and pulse `x_ack_o` for the next cycle;
  - clear the counter;
  - choose the next state: from `BUSY_MEM`, go to `BUSY_IF` if `if_req_i`, else `IDLE`. From `BUSY_IF`, go to `BUSY_MEM` if `mem_req_i`, else `IDLE`.
  - This alternation prevents starvation and adds no bubble.
- **Timeout abort.** If the counter reaches `TIMEOUT_CYC - 1` with no ack, the edge is treated as a completion, except that `x_rdata_o` is 0 and `bus_err_o` pulses with `x_ack_o`.
- **Writes.** `x_rdata_o` is don't-care; the bench checks only the ack.
- **Ignored inputs.** `bus_ack_i` in `IDLE` is ignored. `bus_rdata_i` is sampled only on the completion edge.
- **Stall.** `stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)`. This is combinational.
- **Reset values.** Every output, the state (`IDLE`), the counter, and the latches are 0.
- **Reset mid-transaction.** The in-flight transaction is abandoned and no ack is given. A later `bus_ack_i` in `IDLE` is ignored.

## Timing
- **Minimum latency.** With a zero-wait slave (ack in the first `bus_req_o` cycle):
  - request at edge 0 → `bus_req_o` high in cycle 1;
  - ack sampled at edge 1 → `x_ack_o`/`rdata` valid in cycle 2.
- **Wait states.** Each slave wait state adds one cycle.
- **Bus hold.** `bus_req_o` drops in the cycle after the completion edge, unless a chained grant follows. In that case it stays high with the new command.
- **Ack pulses.** `x_ack_o` is exactly one cycle. The requester may drop `req_i` or present a new one in the cycle after the ack.
- **Timeout.** An abort pulses `x_ack_o` and `bus_err_o` exactly `TIMEOUT_CYC + 1` cycles after the grant edge.
- **Registered outputs.** All outputs except `stallreq_o` come from flops.

## Structure
- Add to `defines.vh`:
  - ``ByteSelBus`` (3:0);
  - state encodings ``ArbIdle``, ``ArbBusyMem``, ``ArbBusyIf``;
  - ``ArbTimeoutDef``.
- Reuse ``RegBus`` and ``InstAddrBus``.
- Single module; no sub-module is warranted. The counter and FSM are small.

## Test plan
- **Single fetch.** `if_req=1`, addr `0x00000040`, zero-wait slave returning `0x24010005` → `bus_addr_o=0x40`, `bus_we_o=0` in cycle 1; `if_ack_o=1` and `if_rdata_o=0x24010005` in cycle 2; `stallreq_o` is 1 in cycles 0-1 and 0 in cycle 2.
- **Simultaneous requests.** `if_req` and `mem_req` (`we=1`, `sel=0xF`, addr `0x100`, data `0xDEADBEEF`) both asserted in cycle 0, slave with 1 wait state → MEM is served first (`bus_we_o=1`); IF is granted with no idle cycle; `mem_ack_o` precedes `if_ack_o` by 2 cycles.
- **Alternation.** Both requesters re-request immediately after every ack for 8 transactions → grants alternate MEM, IF, MEM, IF, …, with no starvation.
- **Timeout.** `TIMEOUT_CYC=4`, slave never acks → `mem_ack_o` and `bus_err_o` pulse together 5 cycles after the grant edge; `mem_rdata_o=0`; FSM returns to `IDLE`.
- **Reset mid-transaction.** `rst` asserted asynchronously while in `BUSY_IF`, then `bus_ack_i` pulses after reset release → all outputs 0 immediately; no `if_ack_o`; the stray ack is ignored.
- **Stale ack in IDLE.** `bus_ack_i=1` with no requests → no state change and no ack outputs.
